// File: rtl/cpu_pkg.sv
// Shared types and defaults for the CPU memory/writeback stage:
// stage states, memory-operation kinds and default widths.
package cpu_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int ADDR_W_DEF      = 32;
    localparam int REG_AW_DEF      = 4;
    localparam int RSP_TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        WB,
        HALTED
    } stage_state_e;

    typedef enum logic [1:0] {
        MEM_OP_NONE,
        MEM_OP_LOAD,
        MEM_OP_STORE
    } mem_op_e;

    // A request flagged as both read and write behaves as a load.
    function automatic mem_op_e decode_mem_op(input logic read_en, input logic write_en);
        if (read_en) begin
            return MEM_OP_LOAD;
        end else if (write_en) begin
            return MEM_OP_STORE;
        end
        return MEM_OP_NONE;
    endfunction

endpackage

// File: rtl/mem_rsp_timer.sv
// Response-wait counter: cleared when a load is issued, counts while waiting,
// flags expiry in the cycle that brings it to RSP_TIMEOUT.
module mem_rsp_timer #(
    parameter int RSP_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(RSP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(RSP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(RSP_TIMEOUT);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_en_i && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    assign expire_o = count_en_i && (count_q == LAST_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access + writeback stage with data-memory handshake and sticky halt.
// Define MEM_MISALIGN_TRAP_EN to trap unaligned LOAD/STORE addresses as bus errors.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int REG_AW      = REG_AW_DEF,
    parameter int RSP_TIMEOUT = RSP_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_rd_value,
    input  logic              ex_reg_write_en,
    input  logic              ex_mem_read_en,
    input  logic              ex_mem_write_en,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    input  logic [DATA_W-1:0] ex_mem_data_out,
    input  logic              ex_halt,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_rsp_valid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              halted,
    output logic              bus_err
);

    stage_state_e      state_q, state_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              regWrite_q, regWrite_d;
    mem_op_e           memOp_q, memOp_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busErr_q, busErr_d;

    logic    accept;
    mem_op_e exMemOp;
    logic    misalignTrap;
    logic    timerClear;
    logic    timerEn;
    logic    timerExpire;

    assign accept  = ex_valid && ex_ready;
    assign exMemOp = decode_mem_op(ex_mem_read_en, ex_mem_write_en);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalignTrap = (exMemOp != MEM_OP_NONE) && (ex_mem_addr[1:0] != 2'b00);
`else
    assign misalignTrap = 1'b0;
`endif

    mem_rsp_timer #(
        .RSP_TIMEOUT(RSP_TIMEOUT)
    ) u_rsp_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (timerClear),
        .count_en_i(timerEn),
        .expire_o  (timerExpire)
    );

    // A response arriving in the same cycle as expiry still wins.
    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        result_d   = result_q;
        regWrite_d = regWrite_q;
        memOp_d    = memOp_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        busErr_d   = busErr_q;
        timerClear = 1'b0;
        timerEn    = 1'b0;

        case (state_q)
            IDLE, WB: begin
                if (accept) begin
                    rd_d       = ex_rd;
                    result_d   = ex_rd_value;
                    regWrite_d = ex_reg_write_en;
                    memOp_d    = exMemOp;
                    addr_d     = ex_mem_addr;
                    wdata_d    = ex_mem_data_out;
                    if (ex_halt) begin
                        state_d = HALTED;
                    end else if (misalignTrap) begin
                        busErr_d = 1'b1;
                        state_d  = HALTED;
                    end else if (exMemOp != MEM_OP_NONE) begin
                        state_d = REQ;
                    end else begin
                        state_d = WB;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (dmem_req_ready) begin
                    if (memOp_q == MEM_OP_LOAD) begin
                        state_d    = WAIT_RSP;
                        timerClear = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WAIT_RSP: begin
                timerEn = 1'b1;
                if (dmem_rsp_valid) begin
                    result_d = dmem_rdata;
                    state_d  = WB;
                end else if (timerExpire) begin
                    busErr_d = 1'b1;
                    state_d  = HALTED;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            result_q   <= '0;
            regWrite_q <= 1'b0;
            memOp_q    <= MEM_OP_NONE;
            addr_q     <= '0;
            wdata_q    <= '0;
            busErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            result_q   <= result_d;
            regWrite_q <= regWrite_d;
            memOp_q    <= memOp_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            busErr_q   <= busErr_d;
        end
    end

    assign ex_ready       = (state_q == IDLE) || (state_q == WB);
    assign dmem_req_valid = (state_q == REQ);
    assign dmem_we        = (state_q == REQ) && (memOp_q == MEM_OP_STORE);
    assign dmem_addr      = addr_q;
    assign dmem_wdata     = wdata_q;
    // Register 0 is hardwired; loads to it still run on the bus.
    assign wb_en          = (state_q == WB) && regWrite_q && (rd_q != '0);
    assign wb_rd          = rd_q;
    assign wb_data        = result_q;
    assign halted         = (state_q == HALTED);
    assign bus_err        = busErr_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: table of ALU ops, hand-written memory corner cases,
// and a randomized instruction stream checked against an in-order register/memory model.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_rd;
    logic [31:0] ex_rd_value;
    logic        ex_reg_write_en;
    logic        ex_mem_read_en;
    logic        ex_mem_write_en;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_mem_data_out;
    logic        ex_halt;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic        wb_en;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        halted;
    logic        bus_err;

    mem_wb_stage #(
        .DATA_W     (32),
        .ADDR_W     (32),
        .REG_AW     (4),
        .RSP_TIMEOUT(8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_rd          (ex_rd),
        .ex_rd_value    (ex_rd_value),
        .ex_reg_write_en(ex_reg_write_en),
        .ex_mem_read_en (ex_mem_read_en),
        .ex_mem_write_en(ex_mem_write_en),
        .ex_mem_addr    (ex_mem_addr),
        .ex_mem_data_out(ex_mem_data_out),
        .ex_halt        (ex_halt),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata),
        .wb_en          (wb_en),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .halted         (halted),
        .bus_err        (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] value;
        logic        wen;
        logic        expWbEn;
    } aluVec_t;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] data;
    } wbExp_t;

    int assertCount = 0;
    int failCount   = 0;

    aluVec_t aluTable[5];
    wbExp_t  expQ[$];
    wbExp_t  expItem;

    logic [31:0] refMem[8];
    logic [31:0] busMem[8];
    int          expStores;
    int          storesSeen;
    logic        randDone;

    int          kind;
    int          waitCnt;
    logic [3:0]  rRd;
    logic [31:0] rVal;
    logic        rWen;
    logic        rRdEn;
    logic        rWrEn;
    logic [31:0] rAddr;
    logic [31:0] rData;

    logic        inReq;
    int          stall;
    logic        pendingRsp;
    int          rspDelay;
    logic [31:0] reqAddr;
    logic        reqWe;
    logic [31:0] reqData;

    // Every comparison funnels through here so the counters stay honest.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] rd, input logic [31:0] val, input logic wen,
                                 input logic rdEn, input logic wrEn, input logic [31:0] addr,
                                 input logic [31:0] data, input logic halt);
        ex_valid        = 1'b1;
        ex_rd           = rd;
        ex_rd_value     = val;
        ex_reg_write_en = wen;
        ex_mem_read_en  = rdEn;
        ex_mem_write_en = wrEn;
        ex_mem_addr     = addr;
        ex_mem_data_out = data;
        ex_halt         = halt;
    endtask

    task automatic clearEx();
        ex_valid        = 1'b0;
        ex_rd           = '0;
        ex_rd_value     = '0;
        ex_reg_write_en = 1'b0;
        ex_mem_read_en  = 1'b0;
        ex_mem_write_en = 1'b0;
        ex_mem_addr     = '0;
        ex_mem_data_out = '0;
        ex_halt         = 1'b0;
    endtask

    // Asserts reset between clock edges, checks the asynchronous clear, then releases.
    task automatic pulseReset(input string tag);
        rst_n = 1'b0;
        #2;
        checkOutput({tag, "_rst_ex_ready"}, 32'(ex_ready), 32'd1);
        checkOutput({tag, "_rst_halted"}, 32'(halted), 32'd0);
        checkOutput({tag, "_rst_bus_err"}, 32'(bus_err), 32'd0);
        checkOutput({tag, "_rst_req_valid"}, 32'(dmem_req_valid), 32'd0);
        rst_n = 1'b1;
        tick();
    endtask

    function automatic int memIndex(input logic [31:0] addr);
        return int'((addr - 32'h100) >> 2);
    endfunction

    initial begin
        aluTable[0] = '{rd: 4'd3,  value: 32'h0000_0005, wen: 1'b1, expWbEn: 1'b1};
        aluTable[1] = '{rd: 4'd0,  value: 32'h0000_0077, wen: 1'b1, expWbEn: 1'b0};
        aluTable[2] = '{rd: 4'd7,  value: 32'hFFFF_FFFF, wen: 1'b0, expWbEn: 1'b0};
        aluTable[3] = '{rd: 4'd15, value: 32'h1234_5678, wen: 1'b1, expWbEn: 1'b1};
        aluTable[4] = '{rd: 4'd1,  value: 32'h0000_0000, wen: 1'b1, expWbEn: 1'b1};

        rst_n          = 1'b0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = '0;
        randDone       = 1'b0;
        clearEx();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ex_ready", 32'(ex_ready), 32'd1);
        checkOutput("reset_req_valid", 32'(dmem_req_valid), 32'd0);
        checkOutput("reset_we", 32'(dmem_we), 32'd0);
        checkOutput("reset_addr", dmem_addr, 32'd0);
        checkOutput("reset_wb_en", 32'(wb_en), 32'd0);
        checkOutput("reset_wb_data", wb_data, 32'd0);
        checkOutput("reset_halted", 32'(halted), 32'd0);
        checkOutput("reset_bus_err", 32'(bus_err), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] ALU table");
        for (int i = 0; i < 5; i++) begin
            checkOutput("alu_pre_ready", 32'(ex_ready), 32'd1);
            applyStimulus(aluTable[i].rd, aluTable[i].value, aluTable[i].wen, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            tick();
            clearEx();
            checkOutput("alu_wb_en", 32'(wb_en), 32'(aluTable[i].expWbEn));
            checkOutput("alu_wb_rd", 32'(wb_rd), 32'(aluTable[i].rd));
            checkOutput("alu_wb_data", wb_data, aluTable[i].value);
            checkOutput("alu_ready_in_wb", 32'(ex_ready), 32'd1);
            tick();
            checkOutput("alu_wb_en_drops", 32'(wb_en), 32'd0);
        end

        $display("[TB] back-to-back ALU");
        applyStimulus(4'd9, 32'hAAAA_0001, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        checkOutput("b2b_first_rd", 32'(wb_rd), 32'd9);
        checkOutput("b2b_first_data", wb_data, 32'hAAAA_0001);
        applyStimulus(4'd10, 32'hBBBB_0002, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        clearEx();
        checkOutput("b2b_second_en", 32'(wb_en), 32'd1);
        checkOutput("b2b_second_rd", 32'(wb_rd), 32'd10);
        checkOutput("b2b_second_data", wb_data, 32'hBBBB_0002);
        tick();

        $display("[TB] store with stalled ready");
        applyStimulus(4'd5, 32'h0, 1'b1, 1'b0, 1'b1, 32'h10, 32'hAB, 1'b0);
        tick();
        clearEx();
        for (int k = 0; k < 4; k++) begin
            checkOutput("st_req_valid", 32'(dmem_req_valid), 32'd1);
            checkOutput("st_we", 32'(dmem_we), 32'd1);
            checkOutput("st_addr", dmem_addr, 32'h10);
            checkOutput("st_wdata", dmem_wdata, 32'hAB);
            checkOutput("st_no_wb", 32'(wb_en), 32'd0);
            checkOutput("st_ex_ready", 32'(ex_ready), 32'd0);
            if (k == 3) dmem_req_ready = 1'b1;
            tick();
        end
        dmem_req_ready = 1'b0;
        checkOutput("st_done_req_valid", 32'(dmem_req_valid), 32'd0);
        checkOutput("st_done_ex_ready", 32'(ex_ready), 32'd1);
        checkOutput("st_done_no_wb", 32'(wb_en), 32'd0);

        $display("[TB] load with two-cycle response");
        applyStimulus(4'd4, 32'h0000_0999, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        tick();
        clearEx();
        checkOutput("ld_req_valid", 32'(dmem_req_valid), 32'd1);
        checkOutput("ld_we", 32'(dmem_we), 32'd0);
        checkOutput("ld_addr", dmem_addr, 32'h20);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checkOutput("ld_wait_ready", 32'(ex_ready), 32'd0);
            checkOutput("ld_wait_no_req", 32'(dmem_req_valid), 32'd0);
            checkOutput("ld_wait_no_wb", 32'(wb_en), 32'd0);
            tick();
        end
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'hDEAD_BEEF;
        tick();
        dmem_rsp_valid = 1'b0;
        checkOutput("ld_wb_en", 32'(wb_en), 32'd1);
        checkOutput("ld_wb_rd", 32'(wb_rd), 32'd4);
        checkOutput("ld_wb_data", wb_data, 32'hDEAD_BEEF);
        tick();

        $display("[TB] stray response in IDLE, load to r0");
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'h1111_1111;
        tick();
        dmem_rsp_valid = 1'b0;
        checkOutput("stray_no_wb", 32'(wb_en), 32'd0);
        checkOutput("stray_ready", 32'(ex_ready), 32'd1);
        applyStimulus(4'd0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
        tick();
        clearEx();
        checkOutput("ld_r0_req", 32'(dmem_req_valid), 32'd1);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'h0000_0055;
        tick();
        dmem_rsp_valid = 1'b0;
        checkOutput("ld_r0_no_wb", 32'(wb_en), 32'd0);
        checkOutput("ld_r0_data", wb_data, 32'h55);
        tick();

        $display("[TB] randomized stream");
        for (int a = 0; a < 8; a++) begin
            refMem[a] = $urandom;
            busMem[a] = refMem[a];
        end
        expStores  = 0;
        storesSeen = 0;
        inReq      = 1'b0;
        pendingRsp = 1'b0;
        stall      = 0;
        rspDelay   = 0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    waitCnt = 0;
                    while (!ex_ready && waitCnt < 50) begin
                        tick();
                        waitCnt++;
                    end
                    if (!ex_ready) begin
                        checkOutput("rand_ex_ready_timeout", 32'(ex_ready), 32'd1);
                        break;
                    end
                    kind  = int'($urandom_range(0, 3));
                    rRd   = 4'($urandom_range(0, 15));
                    rVal  = $urandom;
                    rWen  = ($urandom_range(0, 3) != 0);
                    rAddr = 32'h100 + 32'(4 * $urandom_range(0, 7));
                    rData = $urandom;
                    rRdEn = 1'b0;
                    rWrEn = 1'b0;
                    if (kind == 2) begin
                        rRdEn = 1'b1;
                        rWrEn = ($urandom_range(0, 3) == 0);
                        if (rWen && rRd != 4'd0) expQ.push_back('{rd: rRd, data: refMem[memIndex(rAddr)]});
                    end else if (kind == 3) begin
                        rWrEn = 1'b1;
                        refMem[memIndex(rAddr)] = rData;
                        expStores++;
                    end else begin
                        if (rWen && rRd != 4'd0) expQ.push_back('{rd: rRd, data: rVal});
                    end
                    applyStimulus(rRd, rVal, rWen, rRdEn, rWrEn, rAddr, rData, 1'b0);
                    tick();
                    clearEx();
                    if ($urandom_range(0, 3) == 0) tick();
                end
                repeat (20) tick();
                randDone = 1'b1;
            end
            begin
                while (!randDone) begin
                    tick();
                    dmem_req_ready = 1'b0;
                    dmem_rsp_valid = 1'b0;
                    if (pendingRsp) begin
                        if (rspDelay == 0) begin
                            dmem_rsp_valid = 1'b1;
                            dmem_rdata     = busMem[memIndex(reqAddr)];
                            pendingRsp     = 1'b0;
                        end else begin
                            rspDelay--;
                        end
                    end else if (dmem_req_valid) begin
                        if (!inReq) begin
                            inReq   = 1'b1;
                            stall   = int'($urandom_range(0, 3));
                            reqAddr = dmem_addr;
                            reqWe   = dmem_we;
                            reqData = dmem_wdata;
                        end else begin
                            checkOutput("rand_req_addr_stable", dmem_addr, reqAddr);
                            checkOutput("rand_req_we_stable", 32'(dmem_we), 32'(reqWe));
                        end
                        if (stall == 0) begin
                            dmem_req_ready = 1'b1;
                            inReq          = 1'b0;
                            if (reqWe) begin
                                busMem[memIndex(reqAddr)] = reqData;
                                storesSeen++;
                            end else begin
                                pendingRsp = 1'b1;
                                rspDelay   = int'($urandom_range(0, 3));
                            end
                        end else begin
                            stall--;
                            dmem_rsp_valid = ($urandom_range(0, 1) == 1);
                            dmem_rdata     = $urandom;
                        end
                    end
                end
            end
            begin
                while (!randDone) begin
                    tick();
                    if (wb_en) begin
                        if (expQ.size() == 0) begin
                            checkOutput("rand_unexpected_wb", 32'(wb_en), 32'd0);
                        end else begin
                            expItem = expQ.pop_front();
                            checkOutput("rand_wb_rd", 32'(wb_rd), 32'(expItem.rd));
                            checkOutput("rand_wb_data", wb_data, expItem.data);
                        end
                    end
                end
            end
        join
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        checkOutput("rand_queue_drained", 32'(expQ.size()), 32'd0);
        checkOutput("rand_store_count", 32'(storesSeen), 32'(expStores));
        checkOutput("rand_not_halted", 32'(halted), 32'd0);
        checkOutput("rand_no_bus_err", 32'(bus_err), 32'd0);
        tick();

        $display("[TB] unaligned load");
        applyStimulus(4'd6, 32'h0, 1'b1, 1'b1, 1'b0, 32'h22, 32'h0, 1'b0);
        tick();
        clearEx();
`ifdef MEM_MISALIGN_TRAP_EN
        for (int k = 0; k < 3; k++) begin
            checkOutput("mis_no_req", 32'(dmem_req_valid), 32'd0);
            checkOutput("mis_bus_err", 32'(bus_err), 32'd1);
            checkOutput("mis_halted", 32'(halted), 32'd1);
            tick();
        end
        pulseReset("mis");
`else
        checkOutput("unal_req_valid", 32'(dmem_req_valid), 32'd1);
        checkOutput("unal_addr", dmem_addr, 32'h22);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'hCAFE_0022;
        tick();
        dmem_rsp_valid = 1'b0;
        checkOutput("unal_wb_data", wb_data, 32'hCAFE_0022);
        checkOutput("unal_bus_err", 32'(bus_err), 32'd0);
        tick();
`endif

        $display("[TB] response timeout");
        applyStimulus(4'd2, 32'h0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
        tick();
        clearEx();
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checkOutput("to_wait_not_halted", 32'(halted), 32'd0);
            checkOutput("to_wait_no_err", 32'(bus_err), 32'd0);
            tick();
        end
        checkOutput("to_bus_err", 32'(bus_err), 32'd1);
        checkOutput("to_halted", 32'(halted), 32'd1);
        checkOutput("to_ex_ready", 32'(ex_ready), 32'd0);
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'h7777_7777;
        tick();
        dmem_rsp_valid = 1'b0;
        checkOutput("to_late_rsp_no_wb", 32'(wb_en), 32'd0);
        checkOutput("to_still_halted", 32'(halted), 32'd1);
        pulseReset("to");

        $display("[TB] HALT and reset");
        applyStimulus(4'd8, 32'h0000_0042, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        applyStimulus(4'd8, 32'h0000_0043, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("halt_halted", 32'(halted), 32'd1);
            checkOutput("halt_ex_ready", 32'(ex_ready), 32'd0);
            checkOutput("halt_no_wb", 32'(wb_en), 32'd0);
            checkOutput("halt_no_req", 32'(dmem_req_valid), 32'd0);
            tick();
        end
        clearEx();
        pulseReset("halt");

        $display("[TB] reset during pending request");
        applyStimulus(4'd3, 32'h0, 1'b0, 1'b0, 1'b1, 32'h50, 32'h99, 1'b0);
        tick();
        clearEx();
        checkOutput("midreq_req_valid", 32'(dmem_req_valid), 32'd1);
        pulseReset("midreq");
        checkOutput("midreq_after_idle", 32'(dmem_req_valid), 32'd0);
        applyStimulus(4'd11, 32'h0000_0BAD, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        clearEx();
        checkOutput("post_reset_wb_en", 32'(wb_en), 32'd1);
        checkOutput("post_reset_wb_data", wb_data, 32'h0000_0BAD);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
